// File: rtl/rv32_ctrl_pkg.sv
// Shared opcodes, FSM state and instruction-class types for the RV32I multi-cycle sequencer.
package rv32_ctrl_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [1:0] WR_SEL_ALU = 2'd0;
    localparam logic [1:0] WR_SEL_PC4 = 2'd1;
    localparam logic [1:0] WR_SEL_IMM = 2'd2;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    typedef enum logic [3:0] {
        ClsOp,
        ClsOpImm,
        ClsLui,
        ClsAuipc,
        ClsJal,
        ClsJalr,
        ClsBranch,
        ClsFence,
        ClsSystem,
        ClsIllegal
    } instr_cls_e;

endpackage

// File: rtl/rv32i_multicycle_ctrl_if.sv
// Instruction-memory fetch handshake between the sequencer (master) and memory (slave).
interface rv32i_multicycle_ctrl_if #(
    parameter int unsigned XLEN = 32
) ();

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );

endinterface

// File: rtl/opcode_classifier.sv
// Combinational opcode decode: instruction class plus rd-writing and control-flow flags.
module opcode_classifier
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output instr_cls_e cls,
    output logic       uses_rd,
    output logic       is_control
);

    always_comb begin
        cls = ClsIllegal;
        unique case (opcode)
            OP:          cls = ClsOp;
            OP_IMM:      cls = ClsOpImm;
            LUI:         cls = ClsLui;
            AUIPC:       cls = ClsAuipc;
            JAL:         cls = ClsJal;
            JALR:        cls = ClsJalr;
            BRANCH:      cls = ClsBranch;
            MISC_MEM:    cls = ClsFence;
            SYSTEM:      cls = ClsSystem;
            // Loads and stores trap as illegal.
            LOAD, STORE: cls = ClsIllegal;
            default:     cls = ClsIllegal;
        endcase
    end

    always_comb begin
        uses_rd    = 1'b0;
        is_control = 1'b0;
        unique case (cls)
            ClsOp, ClsOpImm, ClsLui, ClsAuipc: uses_rd = 1'b1;
            ClsJal, ClsJalr: begin
                uses_rd    = 1'b1;
                is_control = 1'b1;
            end
            ClsBranch: is_control = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// RV32I multi-cycle control sequencer: owns PC, IR and ALUOUT and steps
// FETCH -> DECODE -> EXEC -> WB, trapping to HALT on system/illegal/misaligned.
module rv32i_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    rv32i_multicycle_ctrl_if.master  imem,
    output logic [XLEN-1:0]          instr,
    output logic [XLEN-1:0]          pc,
    output logic                     alu_mux1_ctrl,
    output logic                     alu_mux2_ctrl,
    output logic [3:0]               alu_ctrl,
    input  logic [XLEN-1:0]          alu_result,
    input  logic                     br_taken,
    output logic                     rf_wr_en,
    output logic [1:0]               rf_wr_sel,
    output logic                     retire,
    output logic                     halt,
    output logic                     illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] ir_q, ir_d;
    logic [XLEN-1:0] alu_out_q, alu_out_d;
    logic            taken_q, taken_d;
    logic            illegal_q, illegal_d;

    instr_cls_e      cls;
    logic            uses_rd;
    logic            is_control;
    logic            exec_taken;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] wb_target;

    opcode_classifier u_classifier (
        .opcode     (ir_q[6:0]),
        .cls        (cls),
        .uses_rd    (uses_rd),
        .is_control (is_control)
    );

    assign pc_plus4   = pc_q + XLEN'(4);
    assign exec_taken = is_control && ((cls != ClsBranch) || br_taken);

    // JALR targets drop bit 0; JAL/BRANCH targets are used as computed.
    always_comb begin
        wb_target = alu_out_q;
        if (cls == ClsJalr) begin
            wb_target[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_VECTOR;
            ir_q      <= '0;
            alu_out_q <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            alu_out_q <= alu_out_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        alu_out_d = alu_out_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        unique case (state_q)
            StFetch: begin
                if (imem.imem_ready) begin
                    ir_d    = imem.imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                taken_d = 1'b0;
                unique case (cls)
                    ClsFence:  state_d = StWb;
                    ClsSystem: state_d = StHalt;
                    ClsIllegal: begin
                        state_d   = StHalt;
                        illegal_d = 1'b1;
                    end
                    default:   state_d = StExec;
                endcase
            end
            StExec: begin
                alu_out_d = alu_result;
                taken_d   = exec_taken;
                // Bit 1 of the target is unaffected by the JALR bit-0 clear.
                if (exec_taken && alu_result[1]) begin
                    state_d   = StHalt;
                    illegal_d = 1'b1;
                end else begin
                    state_d = StWb;
                end
            end
            StWb: begin
                pc_d    = taken_q ? wb_target : pc_plus4;
                state_d = StFetch;
            end
            StHalt:  state_d = StHalt;
            default: state_d = StFetch;
        endcase
    end

    // Outputs read reset values while rst is held, whatever the current state.
    always_comb begin
        imem.imem_req = 1'b0;
        alu_mux1_ctrl = 1'b0;
        alu_mux2_ctrl = 1'b0;
        alu_ctrl      = ALU_ADD;
        rf_wr_en      = 1'b0;
        rf_wr_sel     = WR_SEL_ALU;
        retire        = 1'b0;
        halt          = 1'b0;
        illegal       = 1'b0;
        if (!rst) begin
            unique case (state_q)
                StFetch: imem.imem_req = 1'b1;
                StExec, StWb: begin
                    unique case (cls)
                        ClsOp: begin
                            alu_mux2_ctrl = 1'b1;
                            alu_ctrl      = {ir_q[14:12], ir_q[30]};
                        end
                        ClsOpImm: alu_ctrl = {ir_q[14:12], (ir_q[14:12] == 3'b101) && ir_q[30]};
                        ClsAuipc, ClsJal, ClsBranch: alu_mux1_ctrl = 1'b1;
                        default: ;
                    endcase
                    if (state_q == StWb) begin
                        retire   = 1'b1;
                        rf_wr_en = uses_rd && (ir_q[11:7] != 5'd0);
                        unique case (cls)
                            ClsJal, ClsJalr: rf_wr_sel = WR_SEL_PC4;
                            ClsLui:          rf_wr_sel = WR_SEL_IMM;
                            default:         rf_wr_sel = WR_SEL_ALU;
                        endcase
                    end
                end
                StHalt: begin
                    halt    = 1'b1;
                    illegal = illegal_q;
                end
                default: ;
            endcase
        end
    end

    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign instr          = ir_q;

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Randomized bench for rv32i_multicycle_ctrl against an instruction-level reference model.
module tb_rv32i_multicycle_ctrl;

    localparam logic [31:0] RV = 32'h0000_0000;

    typedef enum int {KOp, KOpImm, KLui, KAuipc, KJal, KJalr, KBranch, KFence, KSystem, KBad} kind_e;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, pc, alu_result;
    logic        alu_mux1_ctrl, alu_mux2_ctrl, br_taken, rf_wr_en, retire, halt, illegal;
    logic [3:0]  alu_ctrl;
    logic [1:0]  rf_wr_sel;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_pc;
    bit          m_halted;
    bit          m_illegal;

    always #5 clk = ~clk;

    rv32i_multicycle_ctrl_if #(.XLEN(32)) imem ();

    rv32i_multicycle_ctrl #(.XLEN(32), .RESET_VECTOR(RV)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (imem),
        .instr         (instr),
        .pc            (pc),
        .alu_mux1_ctrl (alu_mux1_ctrl),
        .alu_mux2_ctrl (alu_mux2_ctrl),
        .alu_ctrl      (alu_ctrl),
        .alu_result    (alu_result),
        .br_taken      (br_taken),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_sel     (rf_wr_sel),
        .retire        (retire),
        .halt          (halt),
        .illegal       (illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic kind_e kind_of(input logic [31:0] insn);
        case (insn[6:0])
            7'h33:   return KOp;
            7'h13:   return KOpImm;
            7'h37:   return KLui;
            7'h17:   return KAuipc;
            7'h6F:   return KJal;
            7'h67:   return KJalr;
            7'h63:   return KBranch;
            7'h0F:   return KFence;
            7'h73:   return KSystem;
            default: return KBad;
        endcase
    endfunction

    // One instruction from FETCH to retire or trap; model state is updated at the end.
    task automatic run_instr(input logic [31:0] insn, input int wait_cyc,
                             input logic [31:0] alu_val, input logic brt);
        kind_e       k;
        logic        exp_m1, exp_m2, taken, exp_wr;
        logic [3:0]  exp_ctrl;
        logic [1:0]  exp_sel;
        logic [31:0] tgt, nxt;
        k      = kind_of(insn);
        exp_m1 = (k == KAuipc) || (k == KJal) || (k == KBranch);
        exp_m2 = (k == KOp);
        if (k == KOp) exp_ctrl = {insn[14:12], insn[30]};
        else if (k == KOpImm) exp_ctrl = {insn[14:12], (insn[14:12] == 3'b101) && insn[30]};
        else exp_ctrl = 4'b0000;
        taken   = (k == KJal) || (k == KJalr) || ((k == KBranch) && brt);
        tgt     = (k == KJalr) ? (alu_val & 32'hFFFF_FFFE) : alu_val;
        exp_wr  = ((k == KOp) || (k == KOpImm) || (k == KLui) || (k == KAuipc) ||
                   (k == KJal) || (k == KJalr)) && (insn[11:7] != 5'd0);
        exp_sel = ((k == KJal) || (k == KJalr)) ? 2'd1 : (k == KLui) ? 2'd2 : 2'd0;
        nxt     = taken ? tgt : m_pc + 32'd4;

        for (int w = 0; w <= wait_cyc; w++) begin
            @(negedge clk);
            imem.imem_ready = (w == wait_cyc);
            imem.imem_rdata = (w == wait_cyc) ? insn : $urandom();
            alu_result      = $urandom();
            br_taken        = $urandom_range(0, 1) != 0;
            #1;
            check_eq("fetch_req", imem.imem_req, 1);
            check_eq("fetch_addr", imem.imem_addr, m_pc);
            check_eq("fetch_retire", retire, 0);
        end

        @(negedge clk);
        imem.imem_ready = 1'b0;
        imem.imem_rdata = $urandom();
        #1;
        check_eq("decode_ir", instr, insn);
        check_eq("decode_req", imem.imem_req, 0);
        if ((k == KSystem) || (k == KBad)) begin
            @(negedge clk);
            #1;
            check_eq("trap_halt", halt, 1);
            check_eq("trap_illegal", illegal, (k == KBad) ? 1 : 0);
            check_eq("trap_retire", retire, 0);
            m_halted  = 1'b1;
            m_illegal = (k == KBad);
            return;
        end

        if (k != KFence) begin
            @(negedge clk);
            alu_result = alu_val;
            br_taken   = brt;
            #1;
            if (k != KLui) begin
                check_eq("exec_mux1", alu_mux1_ctrl, exp_m1);
                check_eq("exec_mux2", alu_mux2_ctrl, exp_m2);
                check_eq("exec_alu_ctrl", alu_ctrl, exp_ctrl);
            end
            check_eq("exec_wr_en", rf_wr_en, 0);
            if (taken && tgt[1]) begin
                @(negedge clk);
                alu_result = $urandom();
                #1;
                check_eq("misalign_halt", halt, 1);
                check_eq("misalign_illegal", illegal, 1);
                check_eq("misalign_wr_en", rf_wr_en, 0);
                check_eq("misalign_retire", retire, 0);
                check_eq("misalign_pc", pc, m_pc);
                m_halted  = 1'b1;
                m_illegal = 1'b1;
                return;
            end
        end

        @(negedge clk);
        alu_result = $urandom();
        br_taken   = $urandom_range(0, 1) != 0;
        #1;
        check_eq("wb_retire", retire, 1);
        check_eq("wb_wr_en", rf_wr_en, exp_wr);
        if (exp_wr) check_eq("wb_wr_sel", rf_wr_sel, exp_sel);
        if ((k != KLui) && (k != KFence)) begin
            check_eq("wb_mux1", alu_mux1_ctrl, exp_m1);
            check_eq("wb_alu_ctrl", alu_ctrl, exp_ctrl);
        end
        m_pc = nxt;
    endtask

    task automatic hold_and_reset();
        repeat (2) begin
            @(negedge clk);
            imem.imem_ready = 1'b1;
            #1;
            check_eq("halt_held", halt, 1);
            check_eq("halt_illegal", illegal, m_illegal);
            check_eq("halt_req", imem.imem_req, 0);
        end
        @(negedge clk);
        rst             = 1'b1;
        imem.imem_ready = 1'b0;
        #1;
        check_eq("rst_req", imem.imem_req, 0);
        check_eq("rst_halt", halt, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_pc", pc, RV);
        check_eq("post_rst_illegal", illegal, 0);
        m_pc     = RV;
        m_halted = 1'b0;
    endtask

    initial begin
        logic [31:0] r, insn, av;
        logic [6:0]  opc;
        int          sel;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = '0;
        alu_result      = '0;
        br_taken        = 1'b0;
        m_pc            = RV;
        m_halted        = 1'b0;
        m_illegal       = 1'b0;

        @(negedge clk);
        #1;
        check_eq("reset_req", imem.imem_req, 0);
        check_eq("reset_wr_en", rf_wr_en, 0);
        check_eq("reset_retire", retire, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_pc", pc, RV);
        check_eq("reset_ir", instr, 0);
        check_eq("reset_halt", halt, 0);
        check_eq("reset_fetch_req", imem.imem_req, 1);

        run_instr(32'h0050_0093, 0, 32'h5, 1'b0);        // ADDI x1,x0,5
        run_instr(32'h4020_81B3, 3, 32'h1, 1'b0);        // SUB x3,x1,x2
        run_instr(32'h0010_0013, 0, 32'h1, 1'b0);        // ADDI x0,x0,1
        run_instr(32'h0000_2083, 0, 32'h0, 1'b0);        // LW
        hold_and_reset();
        run_instr(32'h0000_0073, 1, 32'h0, 1'b0);        // ECALL
        hold_and_reset();

        // rst in EXEC discards the in-flight ADDI
        @(negedge clk); imem.imem_ready = 1'b1; imem.imem_rdata = 32'h0010_0293; #1;
        @(negedge clk); imem.imem_ready = 1'b0; #1;
        @(negedge clk); rst = 1'b1; #1;
        @(negedge clk); rst = 1'b0; #1;
        check_eq("rst_exec_retire", retire, 0);
        check_eq("rst_exec_wr_en", rf_wr_en, 0);
        check_eq("rst_exec_addr", imem.imem_addr, RV);
        check_eq("rst_exec_req", imem.imem_req, 1);

        // rst wins over a completing fetch
        @(negedge clk); rst = 1'b1; imem.imem_ready = 1'b1; imem.imem_rdata = 32'h0050_0093; #1;
        @(negedge clk); rst = 1'b0; imem.imem_ready = 1'b0; #1;
        check_eq("rst_fetch_ir", instr, 0);
        check_eq("rst_fetch_req", imem.imem_req, 1);
        m_pc = RV;

        repeat (4) run_instr(32'h0000_000F, 0, 32'h0, 1'b0);
        run_instr(32'h0080_00EF, 0, 32'h18, 1'b0);       // JAL x1,+8 at 0x10
        run_instr(32'h0200_0063, 0, 32'h40, 1'b0);       // BEQ at 0x18, not taken
        run_instr(32'h0200_0063, 0, 32'h3C, 1'b1);       // BEQ at 0x1C, taken to 0x3C
        run_instr(32'h0080_00EF, 2, 32'h46, 1'b0);       // JAL, misaligned target
        hold_and_reset();

        for (int i = 0; i < 300; i++) begin
            r   = $urandom();
            sel = $urandom_range(0, 19);
            case (sel)
                0, 1, 2:   opc = 7'h33;
                3, 4, 5:   opc = 7'h13;
                6:         opc = 7'h37;
                7:         opc = 7'h17;
                8, 9:      opc = 7'h6F;
                10, 11:    opc = 7'h67;
                12, 13, 14: opc = 7'h63;
                15, 16:    opc = 7'h0F;
                17:        opc = 7'h73;
                18:        opc = 7'h03;
                default:   opc = ($urandom_range(0, 1) != 0) ? 7'h23 : 7'h7F;
            endcase
            insn = {r[31:7], opc};
            if ($urandom_range(0, 7) == 0) insn[11:7] = 5'd0;
            av = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 5) == 0) av = av | 32'h2;
            run_instr(insn, $urandom_range(0, 3), av, $urandom_range(0, 1) != 0);
            if (m_halted) hold_and_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
